bayer_mosaic_tx: RTL and testbench

Converts a 10-bit-per-channel RGB pixel stream back into a single-channel 10-bit Bayer raw stream. It frames the output with sensor-style FVAL/LVAL timing and X/Y parity bits. The block sits in the camera datapath as a sensor emulator: it drives the raw demosaic/binning stage and the downstream Nios pixel-transfer path from stored or generated RGB frames, so the capture pipeline can be tested without the D8M module attached.

---
 rtl/bayer_mosaic_tx_pkg.sv | 50 +++++
 rtl/bayer_mosaic_tx_if.sv | 27 ++
 rtl/bayer_mosaic_tx_timing_gen.sv | 95 +++++++++
 rtl/bayer_mosaic_tx.sv | 81 ++++++++
 tb/tb_bayer_mosaic_tx.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bayer_mosaic_tx_pkg.sv
// rtl/bayer_mosaic_tx_pkg.sv - shared types, Bayer pattern codes and channel select for bayer_mosaic_tx
package bayer_mosaic_tx_pkg;

   localparam int PIX_W = 10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_SOF,
      ST_ACTIVE,
      ST_HBLANK,
      ST_VBLANK
   } state_e;

   typedef enum logic [1:0] {
      CH_R,
      CH_G,
      CH_B
   } chan_e;

   localparam logic [1:0] PAT_GRBG = 2'd0;
   localparam logic [1:0] PAT_RGGB = 2'd1;
   localparam logic [1:0] PAT_BGGR = 2'd2;
   localparam logic [1:0] PAT_GBRG = 2'd3;

   // Maps {row[0],col[0]} to the colour channel sampled at that site.
   function automatic chan_e bayer_chan(input logic [1:0] pattern, input logic row0, input logic col0);
      chan_e ch;
      ch = CH_G;
      case (pattern)
         PAT_GRBG: begin
            if (!row0 && col0) ch = CH_R;
            else if (row0 && !col0) ch = CH_B;
         end
         PAT_RGGB: begin
            if (!row0 && !col0) ch = CH_R;
            else if (row0 && col0) ch = CH_B;
         end
         PAT_BGGR: begin
            if (!row0 && !col0) ch = CH_B;
            else if (row0 && col0) ch = CH_R;
         end
         default: begin
            if (!row0 && col0) ch = CH_B;
            else if (row0 && !col0) ch = CH_R;
         end
      endcase
      return ch;
   endfunction

endpackage

// File: rtl/bayer_mosaic_tx_if.sv
// rtl/bayer_mosaic_tx_if.sv - RGB pixel input handshake and Bayer raw output bundle
interface bayer_mosaic_tx_if;
   import bayer_mosaic_tx_pkg::*;

   logic [PIX_W-1:0] IN_R;
   logic [PIX_W-1:0] IN_G;
   logic [PIX_W-1:0] IN_B;
   logic             IN_SOF;
   logic             IN_VALID;
   logic             IN_READY;
   logic [PIX_W-1:0] RAW;
   logic             FVAL;
   logic             LVAL;
   logic             X;
   logic             Y;

   modport master (
      output IN_R, IN_G, IN_B, IN_SOF, IN_VALID,
      input  IN_READY, RAW, FVAL, LVAL, X, Y
   );

   modport slave (
      input  IN_R, IN_G, IN_B, IN_SOF, IN_VALID,
      output IN_READY, RAW, FVAL, LVAL, X, Y
   );

endinterface

// File: rtl/bayer_mosaic_tx_timing_gen.sv
// rtl/bayer_mosaic_tx_timing_gen.sv - frame state machine with col/row counters for bayer_mosaic_tx
module bayer_timing_gen
   import bayer_mosaic_tx_pkg::*;
#(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int H_BLANK  = 160,
   parameter int V_BLANK  = 45
) (
   input  logic   CLK,
   input  logic   RESET_N,
   input  logic   ENABLE,
   input  logic   sof_accept,
   output state_e state,
   output logic   col_lsb,
   output logic   row_lsb,
   output logic   last_row,
   output logic   frame_done
);

   localparam int LINE = H_ACTIVE + H_BLANK;
   localparam int ROWS = V_ACTIVE + V_BLANK;
   localparam int CW   = $clog2(LINE);
   localparam int RW   = $clog2(ROWS);

   localparam logic [CW-1:0] COL_ACT_END  = CW'(H_ACTIVE - 1);
   localparam logic [CW-1:0] COL_LINE_END = CW'(LINE - 1);
   localparam logic [CW-1:0] COL_DONE_PRE = CW'(LINE - 2);
   localparam logic [RW-1:0] ROW_ACT_END  = RW'(V_ACTIVE - 1);
   localparam logic [RW-1:0] ROW_FRM_END  = RW'(ROWS - 1);

   logic [CW-1:0] col;
   logic [RW-1:0] row;

   assign col_lsb  = col[0];
   assign row_lsb  = row[0];
   assign last_row = (row == ROW_ACT_END);

   // col spans the whole line period (active + blank); row continues through the
   // vertical blank lines so VBLANK reuses the same two counters.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state      <= ST_IDLE;
         col        <= '0;
         row        <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (ENABLE) state <= ST_WAIT_SOF;
            end
            ST_WAIT_SOF: begin
               if (sof_accept) begin
                  state <= ST_ACTIVE;
                  col   <= CW'(1);
                  row   <= '0;
               end else if (!ENABLE) begin
                  state <= ST_IDLE;
               end
            end
            ST_ACTIVE: begin
               col <= col + CW'(1);
               if (col == COL_ACT_END) state <= ST_HBLANK;
            end
            ST_HBLANK: begin
               if (col == COL_LINE_END) begin
                  col   <= '0;
                  row   <= row + RW'(1);
                  state <= last_row ? ST_VBLANK : ST_ACTIVE;
               end else begin
                  col <= col + CW'(1);
               end
            end
            ST_VBLANK: begin
               // Registered one cycle early so the pulse lands on the final blank cycle.
               if ((row == ROW_FRM_END) && (col == COL_DONE_PRE)) frame_done <= 1'b1;
               if (col == COL_LINE_END) begin
                  col <= '0;
                  if (row == ROW_FRM_END) begin
                     row   <= '0;
                     state <= ENABLE ? ST_WAIT_SOF : ST_IDLE;
                  end else begin
                     row <= row + RW'(1);
                  end
               end else begin
                  col <= col + CW'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/bayer_mosaic_tx.sv
// rtl/bayer_mosaic_tx.sv - RGB to Bayer raw sensor emulator: channel mux, output registers, sticky flags
module bayer_mosaic_tx
   import bayer_mosaic_tx_pkg::*;
#(
   parameter int         H_ACTIVE = 640,
   parameter int         V_ACTIVE = 480,
   parameter int         H_BLANK  = 160,
   parameter int         V_BLANK  = 45,
   parameter logic [1:0] PATTERN  = PAT_GRBG
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             ENABLE,
   bayer_mosaic_tx_if.slave pix,
   output logic             FRAME_DONE,
   output logic             UNDERFLOW,
   output logic             SOF_ERR
);

   state_e           state;
   logic             col_lsb;
   logic             row_lsb;
   logic             last_row;
   logic             sof_accept;
   logic             emit;
   chan_e            chan;
   logic [PIX_W-1:0] pix_sel;

   assign sof_accept   = (state == ST_WAIT_SOF) && pix.IN_VALID && pix.IN_SOF;
   assign emit         = sof_accept || (state == ST_ACTIVE);
   assign pix.IN_READY = (state == ST_WAIT_SOF) || (state == ST_ACTIVE);
   assign chan         = bayer_chan(PATTERN, row_lsb, col_lsb);

   always_comb begin
      pix_sel = pix.IN_G;
      case (chan)
         CH_R:    pix_sel = pix.IN_R;
         CH_B:    pix_sel = pix.IN_B;
         default: pix_sel = pix.IN_G;
      endcase
   end

   bayer_timing_gen #(
      .H_ACTIVE (H_ACTIVE),
      .V_ACTIVE (V_ACTIVE),
      .H_BLANK  (H_BLANK),
      .V_BLANK  (V_BLANK)
   ) u_timing (
      .CLK        (CLK),
      .RESET_N    (RESET_N),
      .ENABLE     (ENABLE),
      .sof_accept (sof_accept),
      .state      (state),
      .col_lsb    (col_lsb),
      .row_lsb    (row_lsb),
      .last_row   (last_row),
      .frame_done (FRAME_DONE)
   );

   // FVAL bridges the horizontal blanks between lines but drops with the last line.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         pix.RAW   <= '0;
         pix.FVAL  <= 1'b0;
         pix.LVAL  <= 1'b0;
         pix.X     <= 1'b0;
         pix.Y     <= 1'b0;
         UNDERFLOW <= 1'b0;
         SOF_ERR   <= 1'b0;
      end else begin
         pix.LVAL <= emit;
         pix.RAW  <= (emit && pix.IN_VALID) ? pix_sel : '0;
         pix.X    <= emit && col_lsb;
         pix.Y    <= emit && row_lsb;
         pix.FVAL <= emit || ((state == ST_HBLANK) && !last_row);
         if ((state == ST_ACTIVE) && !pix.IN_VALID) UNDERFLOW <= 1'b1;
         if ((state == ST_ACTIVE) && pix.IN_VALID && pix.IN_SOF) SOF_ERR <= 1'b1;
      end
   end

endmodule

// File: tb/tb_bayer_mosaic_tx.sv
// tb/tb_bayer_mosaic_tx.sv - scoreboard bench for bayer_mosaic_tx with GRBG and RGGB instances
module tb_bayer_mosaic_tx;

   localparam int H  = 4;
   localparam int V  = 2;
   localparam int HB = 2;
   localparam int VB = 1;

   typedef struct {
      logic [9:0] raw0;
      logic [9:0] raw1;
      logic       x;
      logic       y;
      int         cyc;
   } exp_t;

   logic CLK;
   logic RESET_N;
   logic ENABLE;
   logic fd0, uf0, se0, fd1, uf1, se1;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   last_cyc = 0;
   int   fval_fall_cyc = -1;
   bit   mon_en = 0;
   bit   fval_d = 0;
   exp_t q[$];
   exp_t mon_e;

   bayer_mosaic_tx_if bus0 ();
   bayer_mosaic_tx_if bus1 ();

   assign bus1.IN_R     = bus0.IN_R;
   assign bus1.IN_G     = bus0.IN_G;
   assign bus1.IN_B     = bus0.IN_B;
   assign bus1.IN_SOF   = bus0.IN_SOF;
   assign bus1.IN_VALID = bus0.IN_VALID;

   bayer_mosaic_tx #(.H_ACTIVE(H), .V_ACTIVE(V), .H_BLANK(HB), .V_BLANK(VB), .PATTERN(2'd0)) dut0 (
      .CLK(CLK), .RESET_N(RESET_N), .ENABLE(ENABLE), .pix(bus0),
      .FRAME_DONE(fd0), .UNDERFLOW(uf0), .SOF_ERR(se0)
   );

   bayer_mosaic_tx #(.H_ACTIVE(H), .V_ACTIVE(V), .H_BLANK(HB), .V_BLANK(VB), .PATTERN(2'd1)) dut1 (
      .CLK(CLK), .RESET_N(RESET_N), .ENABLE(ENABLE), .pix(bus1),
      .FRAME_DONE(fd1), .UNDERFLOW(uf1), .SOF_ERR(se1)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc++;

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "bench timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Channel per site: 0=R 1=G 2=B, indexed [pattern][{row0,col0}].
   function automatic logic [9:0] model_raw(input int pat, input int r, input int c,
                                            input logic [9:0] rv, input logic [9:0] gv, input logic [9:0] bv);
      int tbl [4][4];
      int ch;
      tbl = '{'{1, 0, 2, 1}, '{0, 1, 1, 2}, '{2, 1, 1, 0}, '{1, 2, 0, 1}};
      ch  = tbl[pat][(r % 2) * 2 + (c % 2)];
      case (ch)
         0:       return rv;
         1:       return gv;
         default: return bv;
      endcase
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic send(input logic v, input logic s, input logic [9:0] r, input logic [9:0] g,
                       input logic [9:0] b, input int row, input int col, input bit emit);
      bus0.IN_VALID = v;
      bus0.IN_SOF   = s;
      bus0.IN_R     = r;
      bus0.IN_G     = g;
      bus0.IN_B     = b;
      if (emit) begin
         exp_t e;
         check("ready_active", bus0.IN_READY, 1);
         e.raw0 = v ? model_raw(0, row, col, r, g, b) : 10'd0;
         e.raw1 = v ? model_raw(1, row, col, r, g, b) : 10'd0;
         e.x    = col[0];
         e.y    = row[0];
         e.cyc  = cyc + 1;
         q.push_back(e);
         last_cyc = e.cyc;
      end
      tick();
   endtask

   task automatic wait_ready();
      int n = 0;
      while (bus0.IN_READY !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      check("ready_timeout", bus0.IN_READY, 1);
   endtask

   task automatic run_frame(input int n_flush, input int uf_row, input int uf_col, input int se_row,
                            input int se_col, input bit vary, input bit drop_en, input int stop_n);
      int sent = 0;
      logic [9:0] r, g, b;
      wait_ready();
      for (int k = 0; k < n_flush; k++) begin
         if (k == 0) send(1'b0, 1'b1, 10'd900, 10'd901, 10'd902, 0, 0, 1'b0);
         else        send(1'b1, 1'b0, 10'(500 + k), 10'(600 + k), 10'(700 + k), 0, 0, 1'b0);
      end
      for (int row = 0; row < V; row++) begin
         if (drop_en && row == 1) ENABLE = 1'b0;
         for (int col = 0; col < H; col++) begin
            r = vary ? 10'(100 + 10 * row + col) : 10'd1;
            g = vary ? 10'(200 + 10 * row + col) : 10'd2;
            b = vary ? 10'(300 + 10 * row + col) : 10'd3;
            send(!(row == uf_row && col == uf_col),
                 (row == 0 && col == 0) || (row == se_row && col == se_col),
                 r, g, b, row, col, 1'b1);
            sent++;
            if (sent == stop_n) return;
         end
         if (row == V - 1) fval_fall_cyc = last_cyc + 1;
         for (int k = 0; k < HB; k++) begin
            check("ready_hblank", bus0.IN_READY, 0);
            send(1'b1, 1'b1, 10'd999, 10'd999, 10'd999, 0, 0, 1'b0);
         end
      end
      bus0.IN_VALID = 1'b0;
      bus0.IN_SOF   = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      int exp_done;
      exp_done = last_cyc + 7;
      do begin
         @(negedge CLK);
         n++;
      end while (fd0 !== 1'b1 && n < 40);
      check("frame_done_cyc", cyc, exp_done);
      check("frame_done_p1", fd1, 1);
      check("fval_low_at_done", bus0.FVAL, 0);
      tick();
      check("frame_done_pulse", fd0, 0);
   endtask

   always @(negedge CLK) begin
      if (mon_en) begin
         if (bus0.LVAL === 1'b1) begin
            if (q.size() == 0) begin
               check("lval_unexpected", bus0.LVAL, 0);
            end else begin
               mon_e = q.pop_front();
               check("raw_p0", bus0.RAW, mon_e.raw0);
               check("raw_p1", bus1.RAW, mon_e.raw1);
               check("x", bus0.X, mon_e.x);
               check("y", bus0.Y, mon_e.y);
               check("sample_cyc", cyc, mon_e.cyc);
               check("lval_p1", bus1.LVAL, 1);
               check("fval_in_line", bus0.FVAL, 1);
            end
         end else begin
            check("idle_outputs", {bus0.RAW, bus0.X, bus0.Y}, 0);
            check("lval_missing", (q.size() != 0 && q[0].cyc <= cyc), 0);
         end
         if (bus0.FVAL === 1'b1 && !fval_d) check("fval_rise_with_lval", bus0.LVAL, 1);
         if (bus0.FVAL !== 1'b1 && fval_d)  check("fval_fall_cyc", cyc, fval_fall_cyc);
         fval_d = (bus0.FVAL === 1'b1);
      end
   end

   initial begin
      RESET_N       = 1'b0;
      ENABLE        = 1'b1;
      bus0.IN_VALID = 1'b0;
      bus0.IN_SOF   = 1'b0;
      bus0.IN_R     = '0;
      bus0.IN_G     = '0;
      bus0.IN_B     = '0;
      #2;
      check("rst_raw", bus0.RAW, 0);
      check("rst_fval_lval_x_y", {bus0.FVAL, bus0.LVAL, bus0.X, bus0.Y}, 0);
      check("rst_flags", {fd0, uf0, se0}, 0);
      check("rst_ready", bus0.IN_READY, 0);
      tick();
      tick();
      RESET_N = 1'b1;
      mon_en  = 1'b1;

      // Normal frame with flushed pre-SOF pixels and an invalid SOF cycle.
      run_frame(4, -1, -1, -1, -1, 1'b0, 1'b0, 0);
      wait_done();
      check("uf_after_clean", uf0, 0);
      check("se_after_clean", se0, 0);

      // Underflow at row 0 col 2 with per-pixel varying data.
      run_frame(0, 0, 2, -1, -1, 1'b1, 1'b0, 0);
      wait_done();
      check("uf_sticky", uf0, 1);
      check("uf_sticky_p1", uf1, 1);
      check("se_still_clear", se0, 0);

      // Stray SOF at row 1 col 1; ENABLE drops mid-frame but the frame completes.
      run_frame(0, -1, -1, 1, 1, 1'b0, 1'b1, 0);
      wait_done();
      check("se_sticky", se0, 1);
      check("se_sticky_p1", se1, 1);
      check("uf_still_set", uf0, 1);
      for (int k = 0; k < 5; k++) begin
         check("idle_ready_after_disable", bus0.IN_READY, 0);
         tick();
      end

      // Asynchronous reset in row 1, then no SOF so no frame may start.
      ENABLE = 1'b1;
      run_frame(0, -1, -1, -1, -1, 1'b0, 1'b0, H + 2);
      check("pre_reset_lval", bus0.LVAL, 1);
      mon_en  = 1'b0;
      RESET_N = 1'b0;
      #1;
      check("async_rst_raw", bus0.RAW, 0);
      check("async_rst_fval_lval", {bus0.FVAL, bus0.LVAL}, 0);
      check("async_rst_xy", {bus0.X, bus0.Y}, 0);
      check("async_rst_flags", {fd0, uf0, se0, uf1, se1}, 0);
      q.delete();
      fval_d = 1'b0;
      tick();
      tick();
      RESET_N = 1'b1;
      mon_en  = 1'b1;
      for (int k = 0; k < 25; k++) begin
         send(1'b1, 1'b0, 10'(k), 10'(k + 1), 10'(k + 2), 0, 0, 1'b0);
         check("no_sof_fval", bus0.FVAL, 0);
      end
      check("no_sof_waiting", bus0.IN_READY, 1);
      bus0.IN_VALID = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
